// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver blocks.
package uart_rx_pkg;

   typedef enum logic {
      IDLE,
      SAMPLE
   } start_det_state_t;

   localparam int unsigned MAJ_SAMPLES_MIN = 3;
   localparam int unsigned MAJ_SAMPLES_MAX = 5;

   // Half-width of the majority-vote window around mid-bit.
   function automatic int unsigned maj_half(input int unsigned n);
      return (n - 1) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-flop synchroniser for the RX line; resets to the idle (high) level.
module uart_rx_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_start_detect.sv
// Start-bit detector: falling-edge detect, oversample timing and mid-bit
// majority vote, reporting a one-cycle valid or glitch pulse.
module uart_rx_start_detect
   import uart_rx_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned MAJ_SAMPLES = 3,
   parameter int unsigned PRESCALE_W  = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_in,
   input  logic                  enable,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  start_valid,
   output logic                  start_glitch,
   output logic                  sampled_bit,
   output logic                  busy
);

   localparam int unsigned H = maj_half(MAJ_SAMPLES);
   localparam logic [2:0] H3 = 3'(H);

   logic                  rx_s;
   start_det_state_t      state_q, state_d;
   logic [PRESCALE_W-1:0] cnt_q, cnt_d;
   logic [PRESCALE_W-1:0] ps_q, ps_d;
   logic [2:0]            zeros_q, zeros_d;
   logic                  armed_q, armed_d;
   logic                  valid_q, valid_d;
   logic                  glitch_q, glitch_d;
   logic                  sbit_q, sbit_d;
   logic [PRESCALE_W-1:0] mid, win_lo, win_hi;
   logic                  in_window;
   logic                  vote_low;

   uart_rx_sync #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (rx_in),
      .q    (rx_s)
   );

   assign mid       = {1'b0, ps_q[PRESCALE_W-1:1]};
   assign win_lo    = mid - PRESCALE_W'(H);
   assign win_hi    = mid + PRESCALE_W'(H);
   assign in_window = (cnt_q >= win_lo) && (cnt_q <= win_hi);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ps_d     = ps_q;
      zeros_d  = zeros_q;
      armed_d  = armed_q;
      valid_d  = 1'b0;
      glitch_d = 1'b0;
      sbit_d   = sbit_q;
      vote_low = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rx_s) armed_d = 1'b1;
            // Arming requires the line to have been seen high, so a stuck-low line never retriggers.
            if (enable && armed_q && !rx_s) begin
               state_d = SAMPLE;
               ps_d    = prescale;
               cnt_d   = '0;
               zeros_d = '0;
               armed_d = 1'b0;
            end
         end
         SAMPLE: begin
            if (!enable) begin
               state_d = IDLE;
               cnt_d   = '0;
               zeros_d = '0;
            end else if (cnt_q == ps_q - PRESCALE_W'(1)) begin
               vote_low = (zeros_q > H3);
               state_d  = IDLE;
               cnt_d    = '0;
               zeros_d  = '0;
               valid_d  = vote_low;
               glitch_d = !vote_low;
               sbit_d   = !vote_low;
            end else begin
               cnt_d = cnt_q + PRESCALE_W'(1);
               if (in_window && !rx_s) zeros_d = zeros_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ps_q     <= '0;
         zeros_q  <= '0;
         armed_q  <= 1'b0;
         valid_q  <= 1'b0;
         glitch_q <= 1'b0;
         sbit_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ps_q     <= ps_d;
         zeros_q  <= zeros_d;
         armed_q  <= armed_d;
         valid_q  <= valid_d;
         glitch_q <= glitch_d;
         sbit_q   <= sbit_d;
      end
   end

   assign start_valid  = valid_q;
   assign start_glitch = glitch_q;
   assign sampled_bit  = sbit_q;
   assign busy         = (state_q == SAMPLE);

endmodule

// File: tb/tb_uart_rx_start_detect.sv
// Scoreboard bench for uart_rx_start_detect: an M=3 and an M=5 instance share the RX line.
module tb_uart_rx_start_detect;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_in = 1'b1;
   logic       en3 = 1'b0;
   logic       en5 = 1'b0;
   logic [5:0] prescale = 6'd8;
   logic       v3, g3, s3, b3;
   logic       v5, g5, s5, b5;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int t0;

   typedef struct {
      int   cyc;
      logic valid;
      logic sbit;
   } exp_t;

   exp_t q3[$];
   exp_t q5[$];
   exp_t e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_start_detect #(
      .SYNC_STAGES(2),
      .MAJ_SAMPLES(3),
      .PRESCALE_W (6)
   ) dut3 (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_in       (rx_in),
      .enable      (en3),
      .prescale    (prescale),
      .start_valid (v3),
      .start_glitch(g3),
      .sampled_bit (s3),
      .busy        (b3)
   );

   uart_rx_start_detect #(
      .SYNC_STAGES(2),
      .MAJ_SAMPLES(5),
      .PRESCALE_W (6)
   ) dut5 (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_in       (rx_in),
      .enable      (en5),
      .prescale    (prescale),
      .start_valid (v5),
      .start_glitch(g5),
      .sampled_bit (s5),
      .busy        (b5)
   );

   task automatic chk(input string name, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitors: pop an expectation whenever a result pulse appears.
   always @(negedge clk) begin
      if (rst_n && (v3 || g3)) begin
         if (q3.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL dut3 unexpected pulse: valid=%0d glitch=%0d, expected none (cycle %0d)",
                     v3, g3, cyc);
         end else begin
            e = q3.pop_front();
            chk("dut3 pulse cycle", cyc, e.cyc);
            chk("dut3 start_valid", int'(v3), int'(e.valid));
            chk("dut3 start_glitch", int'(g3), int'(!e.valid));
            chk("dut3 sampled_bit", int'(s3), int'(e.sbit));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && (v5 || g5)) begin
         if (q5.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL dut5 unexpected pulse: valid=%0d glitch=%0d, expected none (cycle %0d)",
                     v5, g5, cyc);
         end else begin
            e = q5.pop_front();
            chk("dut5 pulse cycle", cyc, e.cyc);
            chk("dut5 start_valid", int'(v5), int'(e.valid));
            chk("dut5 start_glitch", int'(g5), int'(!e.valid));
            chk("dut5 sampled_bit", int'(s5), int'(e.sbit));
         end
      end
   end

   initial begin
      // Reset values
      tick(3);
      chk("reset dut3 start_valid", int'(v3), 0);
      chk("reset dut3 start_glitch", int'(g3), 0);
      chk("reset dut3 sampled_bit", int'(s3), 1);
      chk("reset dut3 busy", int'(b3), 0);
      chk("reset dut5 start_valid", int'(v5), 0);
      chk("reset dut5 start_glitch", int'(g5), 0);
      chk("reset dut5 sampled_bit", int'(s5), 1);
      chk("reset dut5 busy", int'(b5), 0);
      rst_n = 1'b1;
      tick(5);

      // Clean start, ps=8, M=3: D=t0+2, pulse at D+9
      en3 = 1'b1;
      prescale = 6'd8;
      t0 = cyc;
      q3.push_back('{cyc: t0 + 11, valid: 1'b1, sbit: 1'b0});
      rx_in = 1'b0;
      tick(2);
      chk("clean busy at D", int'(b3), 0);
      tick(1);
      chk("clean busy at D+1", int'(b3), 1);
      tick(7);
      chk("clean busy at D+8", int'(b3), 1);
      tick(1);
      chk("clean busy at D+9", int'(b3), 0);
      tick(1);
      rx_in = 1'b1;
      tick(6);

      // Abort: enable dropped at D+4, line stays low afterwards
      t0 = cyc;
      rx_in = 1'b0;
      tick(6);
      chk("abort busy at D+4", int'(b3), 1);
      en3 = 1'b0;
      tick(1);
      chk("abort busy at D+5", int'(b3), 0);
      tick(1);
      en3 = 1'b1;
      tick(14);
      chk("abort no re-detect busy", int'(b3), 0);
      chk("abort sampled_bit held", int'(s3), 0);
      rx_in = 1'b1;
      tick(6);

      // Glitch: rx_s low only at D and D+1 -> zeros=0 -> glitch at D+9
      t0 = cyc;
      q3.push_back('{cyc: t0 + 11, valid: 1'b0, sbit: 1'b1});
      rx_in = 1'b0;
      tick(2);
      rx_in = 1'b1;
      tick(14);

      // Noisy valid, ps=16, M=5: one high sample at cnt=8 -> zeros=4 -> valid at D+17
      en3 = 1'b0;
      en5 = 1'b1;
      prescale = 6'd16;
      t0 = cyc;
      q5.push_back('{cyc: t0 + 19, valid: 1'b1, sbit: 1'b0});
      for (int i = 0; i < 20; i++) begin
         rx_in = (i == 9);
         tick(1);
      end
      rx_in = 1'b1;
      tick(8);
      en5 = 1'b0;

      // Back-to-back: line high for one rx_s cycle at the first pulse; prescale change ignored
      en3 = 1'b1;
      prescale = 6'd8;
      t0 = cyc;
      q3.push_back('{cyc: t0 + 11, valid: 1'b1, sbit: 1'b0});
      q3.push_back('{cyc: t0 + 21, valid: 1'b1, sbit: 1'b0});
      for (int i = 0; i < 27; i++) begin
         rx_in = (i == 9);
         if (i == 15) prescale = 6'd12;
         tick(1);
      end
      prescale = 6'd8;
      rx_in = 1'b1;
      tick(6);

      // Reset at D+5: everything back to reset values, no pulse
      t0 = cyc;
      rx_in = 1'b0;
      tick(7);
      rst_n = 1'b0;
      #1;
      chk("midreset dut3 busy", int'(b3), 0);
      chk("midreset dut3 start_valid", int'(v3), 0);
      chk("midreset dut3 start_glitch", int'(g3), 0);
      chk("midreset dut3 sampled_bit", int'(s3), 1);
      chk("midreset dut5 sampled_bit", int'(s5), 1);
      rx_in = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(5);
      chk("post-reset dut3 busy", int'(b3), 0);

      // Recovery after reset, ps=6: pulse at D+7
      prescale = 6'd6;
      t0 = cyc;
      q3.push_back('{cyc: t0 + 9, valid: 1'b1, sbit: 1'b0});
      rx_in = 1'b0;
      tick(10);
      rx_in = 1'b1;
      tick(10);

      chk("dut3 expected pulses outstanding", q3.size(), 0);
      chk("dut5 expected pulses outstanding", q5.size(), 0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
